// File: rtl/am_demod_stream_if.sv
// Stream bundle for the AM envelope detector: I/Q samples in, magnitude out,
// plus the DC-blocker controls. No backpressure; valid qualifies each beat.
interface am_demod_stream_if #(
  parameter int DATA_WIDTH = 12
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] inphase;
  logic signed [DATA_WIDTH-1:0] quadrature;
  logic                         dc_block_en;
  logic                         dc_clear;
  logic                         out_valid;
  logic signed [DATA_WIDTH:0]   amdemod_out;

  // Sample source / result sink side
  modport master (
    output in_valid, inphase, quadrature, dc_block_en, dc_clear,
    input  out_valid, amdemod_out
  );

  // Demodulator side
  modport slave (
    input  in_valid, inphase, quadrature, dc_block_en, dc_clear,
    output out_valid, amdemod_out
  );
endinterface

// File: rtl/am_demod_stream.sv
// Streaming AM envelope detector: out = floor(sqrt(I^2 + Q^2)), optionally
// minus a leaky-integrator DC estimate. One sample per clock, fixed latency
// of DATA_WIDTH+3 cycles; the square root resolves one result bit per stage.
module am_demod_stream #(
  parameter int DATA_WIDTH = 12,
  parameter int DC_SHIFT   = 8
) (
  input logic               clk,
  input logic               rst_n,
  am_demod_stream_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int AW = W + DC_SHIFT;   // DC accumulator width
  localparam int RW = W + 2;          // sqrt remainder width
  localparam int NV = W + 3;          // pipeline depth / valid shift length

  // ---------------------------------------------------------------- valid
  logic [NV-1:0] vld_q;

  // Valid bits march alongside the data; bubbles travel in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {NV{1'b0}};
    end else begin
      vld_q <= {vld_q[NV-2:0], bus.in_valid};
    end
  end

  // ------------------------------------------------------- S1/S2 squares
  logic signed [2*W-1:0] i_ext_s;
  logic signed [2*W-1:0] q_ext_s;
  logic signed [2*W-1:0] ii_s;
  logic signed [2*W-1:0] qq_s;
  logic [2*W-1:0]        ii_q;
  logic [2*W-1:0]        qq_q;
  logic [2*W-1:0]        sum_q;

  // Sign-extend before multiplying so (-2^(W-1))^2 is represented exactly.
  assign i_ext_s = {{W{bus.inphase[W-1]}}, bus.inphase};
  assign q_ext_s = {{W{bus.quadrature[W-1]}}, bus.quadrature};
  assign ii_s    = i_ext_s * i_ext_s;
  assign qq_s    = q_ext_s * q_ext_s;

  // Register squares, then their sum (max 2^(2W-1), fits in 2W bits).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ii_q  <= {(2*W){1'b0}};
      qq_q  <= {(2*W){1'b0}};
      sum_q <= {(2*W){1'b0}};
    end else begin
      ii_q  <= $unsigned(ii_s);
      qq_q  <= $unsigned(qq_s);
      sum_q <= ii_q + qq_q;
    end
  end

  // --------------------------------------------------- restoring sqrt
  // Stage j brings down the next two radicand bits, tries (root<<2)|1
  // against the remainder and decides result bit W-1-j.
  for (genvar j = 0; j < W; j++) begin : g_sqrt
    logic [W-1:0]   root_in_s;
    logic [RW-1:0]  rem_in_s;
    logic [2*W-1:0] rad_in_s;
    logic [RW-1:0]  cur_s;
    logic [RW-1:0]  trial_s;
    logic [RW-1:0]  rem_d;
    logic [W-1:0]   root_d;
    logic [W-1:0]   root_q;
    logic [RW-1:0]  rem_q;
    logic [2*W-1:0] rad_q;
    logic           unused_s;

    if (j == 0) begin : g_first
      assign root_in_s = {W{1'b0}};
      assign rem_in_s  = {RW{1'b0}};
      assign rad_in_s  = sum_q;
    end else begin : g_next
      assign root_in_s = g_sqrt[j-1].root_q;
      assign rem_in_s  = g_sqrt[j-1].rem_q;
      assign rad_in_s  = g_sqrt[j-1].rad_q;
    end

    // Incoming remainder is always <= 2*root < 2^W, so its top bits are zero.
    assign unused_s = ^rem_in_s[RW-1 -: 2];
    assign cur_s    = {rem_in_s[RW-3:0], rad_in_s[2*W-1 -: 2]};
    assign trial_s  = {root_in_s, 2'b01};

    // Restoring step: subtract the trial value if it fits, else keep.
    always_comb begin
      rem_d  = cur_s;
      root_d = {root_in_s[W-2:0], 1'b0};
      if (cur_s >= trial_s) begin
        rem_d  = cur_s - trial_s;
        root_d = {root_in_s[W-2:0], 1'b1};
      end else begin
        rem_d  = cur_s;
        root_d = {root_in_s[W-2:0], 1'b0};
      end
    end

    // Register partial root, remainder and the shifted radicand.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        root_q <= {W{1'b0}};
        rem_q  <= {RW{1'b0}};
        rad_q  <= {(2*W){1'b0}};
      end else begin
        root_q <= root_d;
        rem_q  <= rem_d;
        rad_q  <= {rad_in_s[2*W-3:0], 2'b00};
      end
    end
  end

  // Final remainder and exhausted radicand carry no information.
  logic unused_tail_s;
  assign unused_tail_s = ^{g_sqrt[W-1].rem_q, g_sqrt[W-1].rad_q};

  // --------------------------------------------- output / DC blocker
  logic [W-1:0]        mag_s;
  logic [W-1:0]        dc_s;
  logic [AW-1:0]       acc_q;
  logic [AW-1:0]       acc_d;
  logic signed [W:0]   out_q;
  logic signed [W:0]   out_d;

  assign mag_s = g_sqrt[W-1].root_q;
  assign dc_s  = acc_q[AW-1:DC_SHIFT];

  // Output and accumulator both use the pre-update acc; clear wins over update.
  always_comb begin
    out_d = out_q;
    acc_d = acc_q;
    if (vld_q[W+1]) begin
      if (bus.dc_block_en) begin
        out_d = $signed({1'b0, mag_s}) - $signed({1'b0, dc_s});
      end else begin
        out_d = $signed({1'b0, mag_s});
      end
      acc_d = acc_q + {{DC_SHIFT{1'b0}}, mag_s} - {{DC_SHIFT{1'b0}}, dc_s};
    end else begin
      out_d = out_q;
      acc_d = acc_q;
    end
    if (bus.dc_clear) begin
      acc_d = {AW{1'b0}};
    end else begin
      acc_d = acc_d;
    end
  end

  // Output stage registers: result holds between valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= {(W+1){1'b0}};
      acc_q <= {AW{1'b0}};
    end else begin
      out_q <= out_d;
      acc_q <= acc_d;
    end
  end

  assign bus.out_valid   = vld_q[NV-1];
  assign bus.amdemod_out = out_q;

endmodule

// File: tb/tb_am_demod_stream.sv
// Directed bench for am_demod_stream (DATA_WIDTH=12, DC_SHIFT=4).
module tb_am_demod_stream;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  am_demod_stream_if #(.DATA_WIDTH(12)) bus ();

  am_demod_stream #(.DATA_WIDTH(12), .DC_SHIFT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus/expectation tables for short sequences
  logic v_a [8];
  int   i_a [8];
  int   q_a [8];
  int   e_a [8];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int i, input int q);
    bus.in_valid   = v;
    bus.inphase    = 12'(i);
    bus.quadrature = 12'(q);
  endtask

  // Drive n table entries on consecutive cycles, then expect table outputs
  // exactly 15 cycles after each input and no out_valid anywhere else.
  task automatic run(input string name, input int n);
    for (int t = 0; t <= n + 16; t++) begin
      @(negedge clk);
      if (t >= 15 && t < 15 + n) begin
        chk($sformatf("%s_vld%0d", name, t - 15), 32'(bus.out_valid), 32'(v_a[t-15]));
        chk($sformatf("%s_out%0d", name, t - 15), 32'(bus.amdemod_out), 32'(e_a[t-15]));
      end else begin
        chk($sformatf("%s_idle%0d", name, t), 32'(bus.out_valid), 32'd0);
      end
      if (t < n) drive(v_a[t], i_a[t], q_a[t]);
      else       drive(1'b0, 77, -77);
    end
  endtask

  initial begin
    int k;
    int prev;
    int o;
    logic mono_bad;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 0, 0);
    bus.dc_block_en = 1'b0;
    bus.dc_clear    = 1'b0;
    #3;
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.amdemod_out), 32'd0);
    chk("rst_acc", 32'(dut.acc_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single pulse 300/400 -> 500
    v_a[0] = 1'b1; i_a[0] = 300; q_a[0] = 400; e_a[0] = 500;
    run("t1", 1);

    // 2: corners back-to-back
    v_a[0] = 1'b1; i_a[0] = -2048; q_a[0] = -2048; e_a[0] = 2896;
    v_a[1] = 1'b1; i_a[1] = 2047;  q_a[1] = 0;     e_a[1] = 2047;
    v_a[2] = 1'b1; i_a[2] = 0;     q_a[2] = -2048; e_a[2] = 2048;
    v_a[3] = 1'b1; i_a[3] = 0;     q_a[3] = 0;     e_a[3] = 0;
    v_a[4] = 1'b1; i_a[4] = 1;     q_a[4] = 1;     e_a[4] = 1;
    run("t2", 5);

    // 3: valid gaps 1,0,0,1,1; output holds during gaps
    v_a[0] = 1'b1; i_a[0] = 300;  q_a[0] = 400;  e_a[0] = 500;
    v_a[1] = 1'b0; i_a[1] = 1000; q_a[1] = 1000; e_a[1] = 500;
    v_a[2] = 1'b0; i_a[2] = -900; q_a[2] = 5;    e_a[2] = 500;
    v_a[3] = 1'b1; i_a[3] = 3;    q_a[3] = 4;    e_a[3] = 5;
    v_a[4] = 1'b1; i_a[4] = -5;   q_a[4] = 12;   e_a[4] = 13;
    run("t3", 5);

    // 4: DC blocker converges on a constant 500 envelope
    @(negedge clk);
    bus.dc_clear = 1'b1;
    @(negedge clk);
    bus.dc_clear    = 1'b0;
    bus.dc_block_en = 1'b1;
    drive(1'b1, 300, 400);
    k = 0;
    prev = 100000;
    mono_bad = 1'b0;
    for (int c = 0; c < 300 && k < 220; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        k++;
        o = int'(bus.amdemod_out);
        if (k == 1) chk("t4_first", 32'(o), 32'd500);
        if (o > prev) mono_bad = 1'b1;
        prev = o;
        if (k >= 200) begin
          chk($sformatf("t4_zero%0d", k), 32'(o), 32'd0);
          chk($sformatf("t4_acc%0d", k),
              32'((dut.acc_q >= 16'd8000) && (dut.acc_q <= 16'd8015)), 32'd1);
        end
      end
    end
    chk("t4_count", 32'(k), 32'd220);
    chk("t4_mono", 32'(mono_bad), 32'd0);

    // 5: dc_clear coinciding with a valid output; decay restarts
    bus.dc_clear = 1'b1;
    @(negedge clk);
    chk("t5_vld", 32'(bus.out_valid), 32'd1);
    chk("t5_coinc", 32'(bus.amdemod_out), 32'd0);
    chk("t5_acc", 32'(dut.acc_q), 32'd0);
    bus.dc_clear = 1'b0;
    @(negedge clk);
    chk("t5_o0", 32'(bus.amdemod_out), 32'd500);
    @(negedge clk);
    chk("t5_o1", 32'(bus.amdemod_out), 32'd469);
    @(negedge clk);
    chk("t5_o2", 32'(bus.amdemod_out), 32'd440);
    drive(1'b0, 0, 0);
    bus.dc_block_en = 1'b0;
    repeat (20) @(negedge clk);

    // 6: reset with 10 samples in flight
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (t < 10) drive(1'b1, 300, 400);
      else        drive(1'b0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_vld", 32'(bus.out_valid), 32'd0);
    chk("t6_out", 32'(bus.amdemod_out), 32'd0);
    chk("t6_acc", 32'(dut.acc_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      chk($sformatf("t6_stale%0d", t), 32'(bus.out_valid), 32'd0);
    end
    v_a[0] = 1'b1; i_a[0] = 300; q_a[0] = 400; e_a[0] = 500;
    run("t6_after", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
